// File: rtl/i16_extend_if.sv
// Valid/ready sample-entry bus: 16-bit samples in, accumulator-format words out.
interface i16_extend_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 36
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  // Stage side: consumes the input stream, produces the output stream.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // Environment side: upstream source plus downstream sink.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/i16_extend.sv
// Sample-entry stage: sign-extends Q1.15 samples into the accumulator format behind a 2-entry skid buffer.
// Optional rounding bias on bit FRAC_SHIFT-1 when I16_EXTEND_ROUND_BIAS_EN is defined.
module i16_extend #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned OUT_W      = 36,
  parameter int unsigned FRAC_SHIFT = 14,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  i16_extend_if.slave      bus,
  input  logic             flush_i,
  output logic [CNT_W-1:0] sample_cnt_o
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

`ifdef I16_EXTEND_ROUND_BIAS_EN
  // Half-LSB of the 16-bit output grid so a downstream floor truncation rounds to nearest.
  localparam logic [OUT_W-1:0] BIAS = OUT_W'(1) << (FRAC_SHIFT - 1);
`else
  localparam logic [OUT_W-1:0] BIAS = '0;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] m_q, m_d;
  logic [OUT_W-1:0] s_q, s_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] conv_c;
  logic             in_fire_c;
  logic             out_fire_c;

  assign conv_c     = ({{EXT_W{bus.in_data[IN_W-1]}}, bus.in_data} << FRAC_SHIFT) | BIAS;
  assign in_fire_c  = bus.in_valid && in_ready_q;
  assign out_fire_c = out_valid_q && bus.out_ready;

  // Buffer occupancy transitions; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    s_d         = s_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    cnt_d       = cnt_q + (out_fire_c ? CNT_W'(1) : CNT_W'(0));

    unique case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          m_d     = conv_c;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          m_d = conv_c;
        end else if (in_fire_c) begin
          s_d     = conv_c;
          state_d = TWO;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire_c) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush_i) begin
      state_d = EMPTY;
    end

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = m_q;
  assign sample_cnt_o  = cnt_q;

endmodule

// File: doc/i16_extend.md
Name: i16_extend

Overview:
- Sample-entry stage for the IIR datapath. Accepts signed 16-bit Q1.15 samples on a valid/ready stream.
- Sign-extends and scales each sample into the 36-bit accumulator format by shifting left FRAC_SHIFT bits.
- Exact inverse of the 36-to-16 truncation/saturation stage at the filter output: a sample passed through both returns unchanged.
- Has a registered, 2-entry skid-buffered output so the filter core can stall without dropping samples.

Parameters:
- IN_W, 16, input sample width (signed).
- OUT_W, 36, accumulator width (signed). Must satisfy OUT_W >= IN_W + FRAC_SHIFT + 1.
- FRAC_SHIFT, 14, left-shift amount; matches the truncation stage's right shift.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk, input, 1, clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data holds a sample.
- in_ready, output, 1, stage can accept a sample this cycle.
- in_data, input, IN_W, signed sample, Q1.15.
- out_valid, output, 1, out_data holds a converted sample.
- out_ready, input, 1, downstream accepts this cycle.
- out_data, output, OUT_W, signed sign_extend(in_data) <<< FRAC_SHIFT, plus optional bias.
- sample_cnt, output, CNT_W, number of output handshakes since reset; wraps.
- flush, input, 1, synchronous: discard all buffered samples.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, sample_cnt=0.
  - in_ready=1 once reset deasserts. in_ready is 0 while in reset.
  - Both buffer entries invalid.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Conversion:
  - out = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data} <<< FRAC_SHIFT; low FRAC_SHIFT bits are zero (base build).
  - Performed combinationally at the input and registered into the buffer. No overflow is possible given the parameter constraint.
- Buffer: main register M (drives out_data) plus skid register S. States:
  - EMPTY: M, S invalid; in_ready=1, out_valid=0. Input transfer -> ONE (sample into M).
  - ONE: M valid, S invalid; in_ready=1, out_valid=1.
    - In and out together -> ONE (M replaced by new sample).
    - In only -> TWO (new sample into S).
    - Out only -> EMPTY.
  - TWO: M, S valid; in_ready=0, out_valid=1.
    - Out transfer -> ONE (S moves to M).
    - Otherwise hold.
- in_ready is registered: it depends only on the state, never combinationally on out_ready.
- Latency: a sample accepted in cycle N appears on out_data in cycle N+1 when the buffer was EMPTY, or when it was ONE with a simultaneous output transfer.
- Ordering: strict FIFO; no sample is dropped or duplicated.
- sample_cnt:
  - Increments by 1 per output transfer.
  - Wraps from 2^CNT_W-1 to 0.
  - Unaffected by flush.
- flush:
  - Next state EMPTY. out_valid=0 the next cycle.
  - Any input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts.
  - flush takes priority over all other transitions.
- Reset mid-stream: all buffered samples are lost immediately. Downstream must ignore a partial transfer.

Optional Feature:
- Macro: I16_EXTEND_ROUND_BIAS_EN.
- Defined:
  - out_data additionally has bit FRAC_SHIFT-1 set (adds 2^(FRAC_SHIFT-1), i.e. 0x2000 at default parameters).
  - A downstream floor-truncation then rounds to nearest instead of toward minus infinity.
  - The round trip still returns the original sample.
- Undefined: low FRAC_SHIFT bits are zero.

Test Plan:
- Reset, then in_data=16'sh7FFF, out_ready=1 -> one cycle later out_valid=1, out_data=36'h01FFFC000, sample_cnt=1 after the transfer.
- in_data=16'sh8000 -> out_data=36'hFE0000000. in_data=16'shFFFF -> out_data=36'hFFFFFC000. in_data=0 -> out_data=0.
- Stream 1,2,3 with out_ready=0 -> in_ready drops after 2 accepted. out_data holds 36'h000004000. Release -> outputs 0x4000, 0x8000, 0xC000 in order; the third sample is accepted after the stall.
- Buffer in TWO, assert flush for 1 cycle -> out_valid=0 next cycle, in_ready=1, sample_cnt unchanged.
- 65536 back-to-back transfers -> sample_cnt wraps to 0. Assert rst_n=0 mid-transfer -> out_valid and sample_cnt go to 0 immediately.
- Macro defined, in_data=16'sh0001 -> out_data=36'h000006000. Feeding it through the 36-to-16 truncation returns 1.
